// File: rtl/calc_rr_arbiter_if.sv
// Requester and calculator handshake bundle for calc_rr_arbiter.
// slave = arbiter view, master = requester/calculator view.
interface calc_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  req_op;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               calc_go;
    logic [1:0]         calc_op;
    logic [DW-1:0]      calc_in1;
    logic [DW-1:0]      calc_in2;
    logic               calc_done;
    logic [DW-1:0]      calc_out;
    logic               busy;

    modport slave (
        input  req, req_op, req_a, req_b, calc_done, calc_out,
        output gnt, rsp_valid, rsp_data, rsp_err, calc_go, calc_op,
               calc_in1, calc_in2, busy
    );

    modport master (
        output req, req_op, req_a, req_b, calc_done, calc_out,
        input  gnt, rsp_valid, rsp_data, rsp_err, calc_go, calc_op,
               calc_in1, calc_in2, busy
    );
endinterface

// File: rtl/calc_rr_arbiter.sv
// Round-robin share of one calculator among NREQ requesters, with a done watchdog.
// One transaction per (calc latency + 3) cycles; req is only sampled in IDLE.
module calc_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    calc_rr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_result;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic [IW:0]       w_sum;
    logic              w_win_vld;
    logic [IW-1:0]     w_win_idx;
    logic [1:0]        w_sel_op;
    logic [DW-1:0]     w_sel_a;
    logic [DW-1:0]     w_sel_b;
    logic              w_timeout;
    logic [NREQ-1:0]   w_onehot;

    // Rotate so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        w_req2    = {bus.req, bus.req} >> r_ptr;
        w_rot     = w_req2[NREQ-1:0];
        w_win_vld = |w_rot;
        w_sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            end
        end
        if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
        end
        w_win_idx = w_sum[IW-1:0];
    end

    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == IW'(i)) begin
                w_sel_op = bus.req_op[2*i +: 2];
                w_sel_a  = bus.req_a[DW*i +: DW];
                w_sel_b  = bus.req_b[DW*i +: DW];
            end
        end
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_win_vld) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.calc_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_idx    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_idx <= w_win_idx;
                        r_op  <= w_sel_op;
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A done strobe in the final watchdog cycle still counts as success.
                    if (bus.calc_done) begin
                        r_result <= bus.calc_out;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                S_RESP: r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign w_onehot = NREQ'(1) << r_idx;

    always_comb begin
        bus.calc_go   = (r_state == S_ISSUE);
        bus.gnt       = (r_state != S_IDLE) ? w_onehot : '0;
        bus.rsp_valid = (r_state == S_RESP) ? w_onehot : '0;
        bus.rsp_data  = (r_state == S_RESP) ? r_result : '0;
        bus.rsp_err   = (r_state == S_RESP) && r_err;
        bus.busy      = (r_state != S_IDLE);
        bus.calc_op   = r_op;
        bus.calc_in1  = r_a;
        bus.calc_in2  = r_b;
    end
endmodule

// File: tb/tb_calc_rr_arbiter.sv
// Self-checking bench for calc_rr_arbiter: vector table, directed corner sequences, random traffic.
module tb_calc_rr_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    calc_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    calc_rr_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int calc_lat = 1;
    int calc_cnt = 0;
    int go_cnt = 0;
    int m_ptr = 0;
    logic [1:0]    go_op = '0;
    logic [DW-1:0] go_a = '0;
    logic [DW-1:0] go_b = '0;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [1:0]      op;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        int              lat;
        int              idx;
        logic [DW-1:0]   data;
        logic            err;
    } vec_t;

    function automatic logic [DW-1:0] ref_calc(input logic [1:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Calculator model: done arrives lat cycles after go (lat 0 = never), result from held inputs.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            calc_cnt      = 0;
            bus.calc_done = 1'b0;
            bus.calc_out  = '0;
        end else if (bus.calc_go) begin
            calc_cnt      = calc_lat;
            bus.calc_done = 1'b0;
        end else if (calc_cnt > 0) begin
            calc_cnt--;
            bus.calc_done = (calc_cnt == 0);
            if (calc_cnt == 0) bus.calc_out = ref_calc(bus.calc_op, bus.calc_in1, bus.calc_in2);
        end else begin
            bus.calc_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            if (bus.calc_go) begin
                go_cnt++;
                go_op = bus.calc_op;
                go_a  = bus.calc_in1;
                go_b  = bus.calc_in2;
            end else if (bus.gnt != '0) begin
                check("calc_inputs_stable", 32'({bus.calc_op, bus.calc_in1, bus.calc_in2}),
                      32'({go_op, go_a, go_b}));
            end
        end
    end

    task automatic check_zero(input string tag);
        check(tag, 32'({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.calc_go,
                        bus.calc_op, bus.calc_in1, bus.calc_in2, bus.busy}), 32'd0);
    endtask

    task automatic set_all(input logic [NREQ-1:0] r, input logic [1:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req = r;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[2*i +: 2] = op;
            bus.req_a[DW*i +: DW] = a;
            bus.req_b[DW*i +: DW] = b;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait no rsp_valid within 100 cycles, required one");
        end
    endtask

    task automatic expect_rsp(input string tag, input int idx, input logic [DW-1:0] data,
                              input logic err, input int go_before);
        bit ok;
        wait_rsp(ok);
        if (ok) begin
            check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1 << idx);
            check({tag, "_gnt"}, 32'(bus.gnt), 32'd1 << idx);
            check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(data));
            check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(err));
            check({tag, "_go_count"}, 32'(go_cnt - go_before), 32'd1);
        end
        m_ptr = (idx + 1) % NREQ;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t            tbl [10];
        int              g0;
        int              w;
        bit              found;
        bit              ok;
        logic [NREQ-1:0] r;
        logic            e_err;
        logic [DW-1:0]   e_data;
        int              exp_seq [5];

        tbl[0] = '{4'b0100, 2'd0, 4'd5,  4'd3,  3,  2, 4'h8, 1'b0};
        tbl[1] = '{4'b0010, 2'd1, 4'd3,  4'd5,  2,  1, 4'hE, 1'b0};
        tbl[2] = '{4'b0010, 2'd3, 4'hA,  4'h6,  1,  1, 4'hC, 1'b0};
        tbl[3] = '{4'b0100, 2'd2, 4'hC,  4'hA,  4,  2, 4'h8, 1'b0};
        tbl[4] = '{4'b0011, 2'd0, 4'hF,  4'h2,  2,  0, 4'h1, 1'b0};
        tbl[5] = '{4'b0011, 2'd1, 4'h2,  4'h7,  2,  1, 4'hB, 1'b0};
        tbl[6] = '{4'b1000, 2'd0, 4'h3,  4'h4,  0,  3, 4'h0, 1'b1};
        tbl[7] = '{4'b1000, 2'd0, 4'h7,  4'h7,  15, 3, 4'hE, 1'b0};
        tbl[8] = '{4'b0001, 2'd0, 4'h1,  4'h1,  16, 0, 4'h0, 1'b1};
        tbl[9] = '{4'b1001, 2'd3, 4'h5,  4'h5,  1,  3, 4'h0, 1'b0};
        exp_seq = '{0, 1, 2, 3, 0};

        set_all('0, 2'd0, '0, '0);
        repeat (2) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        m_ptr = 0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            calc_lat = tbl[i].lat;
            set_all(tbl[i].req, tbl[i].op, tbl[i].a, tbl[i].b);
            g0 = go_cnt;
            expect_rsp($sformatf("vec%0d", i), tbl[i].idx, tbl[i].data, tbl[i].err, g0);
            check($sformatf("vec%0d_calc_in", i), 32'({bus.calc_in1, bus.calc_in2}),
                  32'({tbl[i].a, tbl[i].b}));
            bus.req = '0;
        end

        // Full contention from reset: strict rotation 0,1,2,3,0.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        calc_lat = 2;
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[2*i +: 2] = 2'd0;
            bus.req_a[DW*i +: DW] = DW'(i);
            bus.req_b[DW*i +: DW] = DW'(1);
        end
        for (int n = 0; n < 5; n++) begin
            g0 = go_cnt;
            expect_rsp($sformatf("contend%0d", n), exp_seq[n], DW'(exp_seq[n] + 1), 1'b0, g0);
        end
        bus.req = '0;

        // Reset in the middle of WAIT, with the pointer parked at 3 beforehand.
        calc_lat = 1;
        set_all(4'b0100, 2'd2, 4'hF, 4'h3);
        g0 = go_cnt;
        expect_rsp("pre_rst", 2, 4'h3, 1'b0, g0);
        calc_lat = 0;
        bus.req = 4'b1000;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.calc_go) found = 1'b1;
        end
        check("rst_mid_wait_go_seen", 32'(found), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_mid_wait_outputs");
        set_all(4'b1010, 2'd1, 4'h9, 4'h2);
        calc_lat = 2;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        g0 = go_cnt;
        expect_rsp("post_rst", 1, 4'h7, 1'b0, g0);

        // Random traffic against a scan-from-pointer reference.
        bus.req = '0;
        for (int it = 0; it < 40; it++) begin
            r = bus.req | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (r == '0) r = NREQ'(1) << $urandom_range(0, NREQ - 1);
            bus.req = r;
            for (int i = 0; i < NREQ; i++) begin
                bus.req_op[2*i +: 2] = 2'($urandom_range(0, 3));
                bus.req_a[DW*i +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
                bus.req_b[DW*i +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
            end
            calc_lat = $urandom_range(0, TIMEOUT + 2);
            w = 0;
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && r[(m_ptr + k) % NREQ]) begin
                    w = (m_ptr + k) % NREQ;
                    found = 1'b1;
                end
            end
            e_err  = (calc_lat == 0) || (calc_lat > TIMEOUT);
            e_data = e_err ? '0 : ref_calc(bus.req_op[2*w +: 2], bus.req_a[DW*w +: DW],
                                           bus.req_b[DW*w +: DW]);
            g0 = go_cnt;
            expect_rsp($sformatf("rand%0d", it), w, e_data, e_err, g0);
            bus.req = r & ~(NREQ'(1) << w);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("final_idle_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_rr_arbiter.md
Name: calc_rr_arbiter

Overview:
- Shares one small-calculator datapath/control unit (go/op/in1/in2 in, done/out back) between NREQ independent requesters.
- Round-robin arbitration; latches the winner's operands and opcode, issues a single go pulse, waits for done, and returns the result to the winner.
- Includes a done-timeout watchdog so a hung calculator cannot lock the arbiter.
- Sits between the requester blocks and the calculator's go/op/input muxes.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, operand/result width.
- TIMEOUT, 15, max WAIT cycles for calc_done before abort (must be > 9).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level; held until own rsp_valid.
- req_op  in  2*NREQ  opcode of requester i at [2i+1:2i]; 0 add, 1 sub, 2 and, 3 xor.
- req_a  in  DW*NREQ  operand A of requester i at [DW*i+DW-1:DW*i].
- req_b  in  DW*NREQ  operand B, same packing.
- gnt  out  NREQ  one-hot grant, high ISSUE through RESP.
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe.
- rsp_data  out  DW  result, valid with rsp_valid.
- rsp_err  out  1  one-cycle, concurrent with rsp_valid on timeout.
- calc_go  out  1  one-cycle start pulse to calculator.
- calc_op  out  2  latched opcode.
- calc_in1  out  DW  latched A.
- calc_in2  out  DW  latched B.
- calc_done  in  1  calculator completion strobe.
- calc_out  in  DW  calculator result, valid with calc_done.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: every output is 0; ptr=0; state=IDLE; latched idx/op/a/b/result and wait counter are 0.
- FSM is registered, states IDLE, ISSUE, WAIT, RESP. Outputs are registered/decoded from state, never from req combinationally.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... NREQ-1, 0, ... (wrap).
  - Latch idx, req_op, req_a and req_b of the winner, then go to ISSUE. Otherwise stay.
- ISSUE:
  - calc_go=1 for exactly this cycle; gnt[idx]=1; clear the wait counter.
  - Go to WAIT.
- WAIT:
  - calc_go=0; counter increments each cycle.
  - calc_done=1: capture calc_out, go to RESP with err=0.
  - Else counter==TIMEOUT-1: set result=0, err=1, go to RESP.
  - calc_done takes priority over timeout in the same cycle.
- RESP:
  - rsp_valid[idx]=1, rsp_data=result, rsp_err=err for one cycle.
  - ptr <= (idx+1) mod NREQ, then go to IDLE.
- calc_op, calc_in1 and calc_in2 are held stable from ISSUE until the next IDLE→ISSUE. The calculator samples in1 and in2 on later cycles, so the inputs must not change while busy.
- req is sampled only in IDLE. There is at least one IDLE cycle between transactions; a back-to-back throughput cap of 1 transaction per (latency+3) cycles is accepted.
- Requester drops req mid-transaction: the transaction still completes and rsp_valid is still pulsed; there is no cancel.
- calc_done outside WAIT is ignored.
- rsp_data is DW bits, modulo 2^DW; the arbiter does no arithmetic.
- rst mid-transaction: immediate return to reset values; calc_go drops the same cycle; the calculator is reset by the same rst.

Test Plan:
- Single request: DW=4, req=4'b0100, op=0, a=5, b=3 → one calc_go pulse; gnt=4'b0100; calc_in1=5, calc_in2=3 stable through WAIT; rsp_valid=4'b0100 with rsp_data=8, rsp_err=0; ptr=3.
- Wrap arithmetic: requester 1, op=1, a=3, b=5 → rsp_data=4'hE. Op=3, a=4'hA, b=4'h6 → 4'hC.
- Full contention: req=4'b1111 held after reset → grant order 0,1,2,3,0; exactly one calc_go per grant; gnt is never multi-hot.
- Pointer wrap: after serving requester 2 (ptr=3), req=4'b0011 → requester 0 granted, then requester 1.
- Timeout: calculator model holds calc_done=0 → after TIMEOUT(15) WAIT cycles rsp_valid[idx]=1, rsp_err=1, rsp_data=0; the next request is served normally. A variant asserting calc_done in cycle 15 gives rsp_err=0 with the correct data.
- Reset mid-WAIT: assert rst 3 cycles after calc_go → all outputs 0 the same cycle, ptr=0; after release, pending req=4'b0010 is served as requester 1.
